// File: rtl/dmem_responder_if.sv
// Load/store bus between the memory pipeline stage and the data memory responder.
// The master issues one access per cycle; the slave answers with registered data and fault.
interface dmem_responder_if;
   logic        MemWriteM;
   logic        MemReadM;
   logic [31:0] AddrM;
   logic [31:0] WriteDataM;
   logic [1:0]  SizeM;
   logic [31:0] ReadData;
   logic        FaultW;

   modport master (
      output MemWriteM, MemReadM, AddrM, WriteDataM, SizeM,
      input  ReadData, FaultW
   );

   modport slave (
      input  MemWriteM, MemReadM, AddrM, WriteDataM, SizeM,
      output ReadData, FaultW
   );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: byte-lane RAM, a 64-bit free-running cycle counter and a scratch
// register, with a one-cycle registered load path and a registered fault flag.
module dmem_responder #(
   parameter int DEPTH = 1024
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [31:0] ADDR_CNT_LO  = 32'hFFFF_0000;
   localparam logic [31:0] ADDR_CNT_HI  = 32'hFFFF_0004;
   localparam logic [31:0] ADDR_SCRATCH = 32'hFFFF_0008;

   logic [31:0] r_mem [DEPTH];
   logic [63:0] r_cnt;
   logic [31:0] r_scratch;
   logic [31:0] r_readData;
   logic        r_fault;

   logic          w_store;
   logic          w_load;
   logic          w_isRam;
   logic          w_isCntLo;
   logic          w_isCntHi;
   logic          w_isScratch;
   logic          w_isReg;
   logic          w_misaligned;
   logic          w_fault;
   logic          w_okStore;
   logic [AW-1:0] w_ramIdx;
   logic [3:0]    w_byteEn;
   logic [31:0]   w_wrData;
   logic [31:0]   w_wordData;
   logic [31:0]   w_shifted;
   logic [31:0]   w_loadData;

   // A simultaneous read and write is a store; the load path then holds its value.
   assign w_store     = bus.MemWriteM;
   assign w_load      = bus.MemReadM & ~bus.MemWriteM;
   assign w_isRam     = (bus.AddrM[31:AW+2] == '0);
   assign w_isCntLo   = (bus.AddrM == ADDR_CNT_LO);
   assign w_isCntHi   = (bus.AddrM == ADDR_CNT_HI);
   assign w_isScratch = (bus.AddrM == ADDR_SCRATCH);
   assign w_isReg     = w_isCntLo | w_isCntHi | w_isScratch;
   assign w_ramIdx    = bus.AddrM[AW+1:2];

   always_comb begin
      w_misaligned = 1'b0;
      case (bus.SizeM)
         2'b00:   w_misaligned = 1'b0;
         2'b01:   w_misaligned = bus.AddrM[0];
         2'b10:   w_misaligned = (bus.AddrM[1:0] != 2'b00);
         default: w_misaligned = 1'b1;
      endcase
      if (w_isReg && bus.SizeM != 2'b10) begin
         w_misaligned = 1'b1;
      end
   end

   assign w_fault   = (bus.MemWriteM | bus.MemReadM) & (w_misaligned | ~(w_isRam | w_isReg));
   assign w_okStore = w_store & ~w_fault & ~reset;

   // Store lanes: the low byte/half of the write data is moved up to its lane.
   always_comb begin
      w_byteEn = 4'b0000;
      case (bus.SizeM)
         2'b00:   w_byteEn = 4'b0001 << bus.AddrM[1:0];
         2'b01:   w_byteEn = bus.AddrM[1] ? 4'b1100 : 4'b0011;
         2'b10:   w_byteEn = 4'b1111;
         default: w_byteEn = 4'b0000;
      endcase
   end
   assign w_wrData = bus.WriteDataM << {bus.AddrM[1:0], 3'b000};

   always_comb begin
      w_wordData = r_mem[w_ramIdx];
      if (w_isCntLo) begin
         w_wordData = r_cnt[31:0];
      end else if (w_isCntHi) begin
         w_wordData = r_cnt[63:32];
      end else if (w_isScratch) begin
         w_wordData = r_scratch;
      end
   end

   // Loads are right-justified and zero-filled; sign extension happens downstream.
   assign w_shifted = w_wordData >> {bus.AddrM[1:0], 3'b000};

   always_comb begin
      w_loadData = w_wordData;
      case (bus.SizeM)
         2'b00:   w_loadData = {24'b0, w_shifted[7:0]};
         2'b01:   w_loadData = {16'b0, w_shifted[15:0]};
         default: w_loadData = w_wordData;
      endcase
   end

   // RAM has no reset so it can map onto block memory; writes are per byte lane.
   always_ff @(posedge clk) begin
      if (w_okStore && w_isRam) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byteEn[b]) begin
               r_mem[w_ramIdx][8*b +: 8] <= w_wrData[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_scratch  <= '0;
         r_readData <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_fault <= w_fault;
         if (w_fault) begin
            r_readData <= '0;
         end else if (w_load) begin
            r_readData <= w_loadData;
         end
         if (w_okStore && w_isScratch) begin
            r_scratch <= bus.WriteDataM;
         end
         // A counter store replaces one half and suppresses that cycle's increment.
         if (w_okStore && w_isCntLo) begin
            r_cnt[31:0] <= bus.WriteDataM;
         end else if (w_okStore && w_isCntHi) begin
            r_cnt[63:32] <= bus.WriteDataM;
         end else begin
            r_cnt <= r_cnt + 64'd1;
         end
      end
   end

   assign bus.ReadData = r_readData;
   assign bus.FaultW   = r_fault;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of directed vectors followed by a
// randomized store/load-back pass; expected results go through a scoreboard queue.
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [1:0] SX = 2'b11;

   typedef struct {
      logic        rst;
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic [31:0] expRd;
      logic        expFault;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        fault;
   } exp_t;

   logic clk;
   logic reset;
   int   nVec;
   int   nMiss;
   vec_t vecs[$];
   exp_t expQ[$];

   dmem_responder_if bus ();

   dmem_responder #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t V(input logic rst, input logic we, input logic re,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic [31:0] expRd,
                              input logic expFault);
      vec_t v;
      v.rst = rst; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
      v.size = size; v.expRd = expRd; v.expFault = expFault;
      return v;
   endfunction

   task automatic checkOutput(input string tag);
      exp_t e;
      if (expQ.size() == 0) begin
         nMiss++;
         $display("[TB] FAIL %s: scoreboard empty, got rd=%h fault=%b", tag, bus.ReadData, bus.FaultW);
         return;
      end
      e = expQ.pop_front();
      if (bus.ReadData !== e.rd) begin
         nMiss++;
         $display("[TB] FAIL %s ReadData: got %h expected %h", tag, bus.ReadData, e.rd);
      end
      if (bus.FaultW !== e.fault) begin
         nMiss++;
         $display("[TB] FAIL %s FaultW: got %b expected %b", tag, bus.FaultW, e.fault);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      reset          = v.rst;
      bus.MemWriteM  = v.we;
      bus.MemReadM   = v.re;
      bus.AddrM      = v.addr;
      bus.WriteDataM = v.wdata;
      bus.SizeM      = v.size;
      e.rd    = v.expRd;
      e.fault = v.expFault;
      expQ.push_back(e);
      nVec++;
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      logic [31:0] held;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] expData;
      logic [1:0]  size;

      nVec  = 0;
      nMiss = 0;
      reset = 1'b1;
      bus.MemWriteM  = 1'b0;
      bus.MemReadM   = 1'b0;
      bus.AddrM      = '0;
      bus.WriteDataM = '0;
      bus.SizeM      = SW;

      //           rst we re addr           wdata          size expRd          flt
      // Reset state, and a load presented during reset is ignored
      vecs.push_back(V(1, 0, 0, 32'h0,        32'h0,        SW, 32'h0,         0));
      vecs.push_back(V(1, 0, 1, 32'h10,       32'h0,        SW, 32'h0,         0));
      // Word store then byte/half/word extraction
      vecs.push_back(V(0, 1, 0, 32'h10,       32'h12345678, SW, 32'h0,         0));
      vecs.push_back(V(0, 0, 1, 32'h11,       32'h0,        SB, 32'h00000056,  0));
      vecs.push_back(V(0, 0, 1, 32'h12,       32'h0,        SH, 32'h00001234,  0));
      vecs.push_back(V(0, 0, 1, 32'h10,       32'h0,        SW, 32'h12345678,  0));
      // Byte store uses only the low byte of the write data
      vecs.push_back(V(0, 1, 0, 32'h13,       32'hFFFFFFAB, SB, 32'h12345678,  0));
      vecs.push_back(V(0, 0, 1, 32'h10,       32'h0,        SW, 32'hAB345678,  0));
      vecs.push_back(V(0, 1, 0, 32'h00,       32'hCAFEF00D, SW, 32'hAB345678,  0));
      // Faults: misaligned load, misaligned store, unmapped load
      vecs.push_back(V(0, 0, 1, 32'h12,       32'h0,        SW, 32'h0,         1));
      vecs.push_back(V(0, 1, 0, 32'h03,       32'h00001111, SH, 32'h0,         1));
      vecs.push_back(V(0, 0, 1, 32'h8000,     32'h0,        SW, 32'h0,         1));
      vecs.push_back(V(0, 0, 0, 32'h0,        32'h0,        SW, 32'h0,         0));
      vecs.push_back(V(0, 0, 1, 32'h00,       32'h0,        SW, 32'hCAFEF00D,  0));
      vecs.push_back(V(0, 0, 1, 32'h10,       32'h0,        SW, 32'hAB345678,  0));
      // Read+write together is a store; ReadData holds
      vecs.push_back(V(0, 1, 1, 32'h20,       32'hDEADBEEF, SW, 32'hAB345678,  0));
      vecs.push_back(V(0, 0, 1, 32'h20,       32'h0,        SW, 32'hDEADBEEF,  0));
      vecs.push_back(V(0, 1, 0, 32'h22,       32'hFFFF9876, SH, 32'hDEADBEEF,  0));
      vecs.push_back(V(0, 0, 1, 32'h20,       32'h0,        SW, 32'h9876BEEF,  0));
      vecs.push_back(V(0, 1, 0, 32'h20,       32'h00000001, SB, 32'h9876BEEF,  0));
      vecs.push_back(V(0, 0, 1, 32'h20,       32'h0,        SH, 32'h0000BE01,  0));
      vecs.push_back(V(0, 0, 1, 32'h23,       32'h0,        SB, 32'h00000098,  0));
      vecs.push_back(V(0, 0, 1, 32'h20,       32'h0,        SX, 32'h0,         1));
      // Scratch register: word only, other sizes fault
      vecs.push_back(V(0, 1, 0, 32'hFFFF0008, 32'h00000055, SW, 32'h0,         0));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h00000055,  0));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SH, 32'h0,         1));
      vecs.push_back(V(0, 1, 0, 32'hFFFF0008, 32'h000000EE, SB, 32'h0,         1));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h00000055,  0));
      vecs.push_back(V(0, 0, 1, 32'hFFFF000C, 32'h0,        SW, 32'h0,         1));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h00000055,  0));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0002, 32'h0,        SW, 32'h0,         1));
      // Reset with a load pending: aborted, scratch cleared
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h00000055,  0));
      vecs.push_back(V(1, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h0,         0));
      vecs.push_back(V(0, 0, 1, 32'hFFFF0008, 32'h0,        SW, 32'h0,         0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Counter sequence: starts at 0 after reset, low-word wrap, no carry on a half store
      applyStimulus(V(1, 0, 0, 32'h0,        32'h0,        SW, 32'h0,        0), "cnt reset");
      applyStimulus(V(0, 0, 1, 32'hFFFF0000, 32'h0,        SW, 32'h0,        0), "cnt first lo");
      applyStimulus(V(0, 0, 1, 32'hFFFF0000, 32'h0,        SW, 32'h1,        0), "cnt second lo");
      applyStimulus(V(0, 0, 1, 32'hFFFF0004, 32'h0,        SW, 32'h0,        0), "cnt hi zero");
      applyStimulus(V(0, 1, 0, 32'hFFFF0000, 32'hFFFFFFFF, SW, 32'h0,        0), "cnt store lo");
      applyStimulus(V(0, 1, 0, 32'hFFFF0004, 32'h0,        SW, 32'h0,        0), "cnt store hi");
      applyStimulus(V(0, 0, 0, 32'h0,        32'h0,        SW, 32'h0,        0), "cnt idle");
      applyStimulus(V(0, 0, 1, 32'hFFFF0004, 32'h0,        SW, 32'h1,        0), "cnt wrapped hi");
      applyStimulus(V(0, 0, 1, 32'hFFFF0000, 32'h0,        SW, 32'h1,        0), "cnt wrapped lo");
      applyStimulus(V(0, 1, 0, 32'hFFFF0004, 32'hA5A5A5A5, SW, 32'h1,        0), "cnt store hi2");
      applyStimulus(V(0, 0, 1, 32'hFFFF0004, 32'h0,        SW, 32'hA5A5A5A5, 0), "cnt read hi2");
      applyStimulus(V(0, 0, 1, 32'hFFFF0000, 32'h0,        SW, 32'h3,        0), "cnt lo held");
      held = 32'h3;

      // Randomized store then immediate load-back of a random size and lane
      for (int i = 0; i < 16; i++) begin
         size = 2'($urandom_range(0, 2));
         addr = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
         if (size == SB) begin
            addr[1:0] = 2'($urandom_range(0, 3));
         end else if (size == SH) begin
            addr[1] = 1'($urandom_range(0, 1));
         end
         data = $urandom;
         case (size)
            SB:      expData = {24'b0, data[7:0]};
            SH:      expData = {16'b0, data[15:0]};
            default: expData = data;
         endcase
         applyStimulus(V(0, 1, 0, addr, data, size, held, 0), $sformatf("rnd%0d store", i));
         applyStimulus(V(0, 0, 1, addr, 32'h0, size, expData, 0), $sformatf("rnd%0d load", i));
         held = expData;
      end
      applyStimulus(V(0, 0, 0, 32'h0, 32'h0, SW, held, 0), "final idle");

      if (expQ.size() != 0) begin
         nMiss++;
         $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end
endmodule
